line_buffer_array: RTL
======================

// Module: line_buffer_array
// PURPOSE
//  Parametrised vertical line-buffer array; successor to the fixed 16-row buffer. Streams a raster
//  image (one pixel/cycle max) and presents NUM_TAPS vertically aligned pixels (same column, rows
//  r, r-1, ... r-NUM_TAPS+1) to the window/filter stage. Adds valid/ready flow control, row/col
//  tracking, fill qualification and a self-timed end-of-frame flush with pad pixels.
// PARAMETERS
//  DATA_W     8     pixel width, bits
//  IMG_W      640   pixels per row (>=2)
//  NUM_TAPS   17    vertical taps; NUM_TAPS-1 row delays instantiated (>=2)
//  PAD_VALUE  0     pixel injected during flush
//  FLUSH_ROWS NUM_TAPS-1  rows of padding pushed after end of frame (0 = no flush)
// PORTS
//  clk       in   1                  clock, rising edge
//  rst       in   1                  asynchronous, active-high reset
//  clear_i   in   1                  synchronous abort; returns to IDLE, same values as reset
//  valid_i   in   1                  data_i qualifier
//  ready_o   out  1                  block accepts a pixel this cycle
//  data_i    in   DATA_W             input pixel, raster order
//  eof_i     in   1                  marks last pixel of frame (sampled with valid_i & ready_o)
//  taps_o    out  NUM_TAPS*DATA_W    tap k at [k*DATA_W +: DATA_W]; tap 0 = newest row
//  valid_o   out  1                  taps_o holds a fully populated column
//  col_o     out  clog2(IMG_W)       column of taps_o
//  row_o     out  16                 row index of tap 0 (saturates at 0xFFFF)
//  done_o    out  1                  one-cycle pulse with final flushed output
// BEHAVIOUR
//  - Reset/clear: taps_o=0, valid_o=0, done_o=0, col_o=0, row_o=0, ready_o=0 (during reset),
//    FSM=IDLE, delay-line contents don't-care (never exposed: valid_o gates them).
//  - Accept = valid_i & ready_o. ready_o=1 in IDLE/FILL/RUN, 0 in FLUSH. Nothing shifts
//    without an accept or a flush beat; gaps in valid_i stall all state.
//  - Latency: 1 cycle. Pixel accepted at cycle t appears on tap 0 at t+1 with taps 1..NUM_TAPS-1
//    = pixels of same column from previous rows.
//  - col counter wraps IMG_W-1 -> 0 and increments row counter.
//  - FSM: IDLE -(first accept)-> FILL; FILL -(row counter reaches NUM_TAPS-1 at col 0)-> RUN;
//    FILL/RUN -(accept with eof_i)-> FLUSH if FLUSH_ROWS>0 else IDLE (done_o pulses with that
//    pixel's output); FLUSH -(FLUSH_ROWS*IMG_W beats done)-> IDLE.
//  - valid_o=1 for outputs whose row index >= NUM_TAPS-1, i.e. in RUN and FLUSH beats.
//  - FLUSH: one PAD_VALUE beat per cycle into tap 0, counters advance as normal; done_o
//    pulses with the last flush output. valid_i ignored.
//  - eof_i mid-row: flush still pads FLUSH_ROWS*IMG_W beats from current column; row alignment
//    is the producer's responsibility.
//  - eof_i during FILL: go to FLUSH; valid_o rises once padded rows complete history.
//  - clear_i wins over any simultaneous accept/flush beat. Async rst mid-frame: same.
//  - Next frame may start the cycle after FSM returns to IDLE (ready_o high again).
// STRUCTURE
//  - Package lba_pkg: FSM state enum (IDLE, FILL, RUN, FLUSH), clog2 helper, tap index macros.
//  - Sub-module row_delay: IMG_W-deep single-port circular RAM/shift register, DATA_W wide,
//    shift-enable input; generate-chain of NUM_TAPS-1 instances, enable shared across all.
//  - Top holds FSM, col/row/flush counters, output registers.
// TESTING (DATA_W=8, IMG_W=4, NUM_TAPS=3, FLUSH_ROWS=2 unless noted)
//  1 Ramp 0..15 continuous, eof on 15 -> first valid_o on pixel 8 output, taps={0,4,8}
//    (tap2,tap1,tap0), col_o=0,row_o=2; pixel 15 -> {7,11,15}.
//  2 Same, then flush -> 8 more valid beats, first taps={8,12,0}, last {15,0,0}, done_o on last.
//  3 Random valid_i gaps (50%) -> identical taps/valid_o sequence as 1 after removing idle cycles.
//  4 clear_i asserted in RUN at pixel 10 -> next cycle valid_o=0, row_o=0, FSM IDLE; new ramp
//    reproduces test 1 exactly.
//  5 FLUSH_ROWS=0, eof on 15 -> done_o with pixel 15 output, ready_o never drops.
//  6 Back-to-back frames: second frame first pixel offered during FLUSH -> held off (ready_o=0),
//    accepted first cycle after done_o; output matches test 1.

Source files
------------

// File: rtl/lba_pkg.sv
// Shared types and helpers for the vertical line-buffer array: FSM states,
// a constant-safe clog2 and the tap slice position inside the packed tap bus.
package lba_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN,
        ST_FLUSH
    } lba_state_t;

    // Never returns less than 1 so a counter sized with it always has a bit.
    function automatic int clog2(input int value);
        int result = 1;
        while ((1 << result) < value) result++;
        return result;
    endfunction

    function automatic int tap_lsb(input int tap, input int data_w);
        return tap * data_w;
    endfunction

endpackage

// File: rtl/row_delay.sv
// One image-row delay: a DEPTH-entry circular buffer that returns the sample
// written DEPTH enabled beats ago and stores the new one in the same slot.
module row_delay
    import lba_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 640
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    localparam int PTR_W = clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  ptr;

    // Read-before-write on the same slot gives exactly DEPTH beats of delay.
    assign dout = mem[ptr];

    always_ff @(posedge clk) begin
        if (en) mem[ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/line_buffer_array.sv
// Vertical line-buffer array: streams a raster image and presents NUM_TAPS
// pixels of the same column from consecutive rows, with an end-of-frame pad flush.
module line_buffer_array
    import lba_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter int                IMG_W      = 640,
    parameter int                NUM_TAPS   = 17,
    parameter logic [DATA_W-1:0] PAD_VALUE  = '0,
    parameter int                FLUSH_ROWS = NUM_TAPS - 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic [DATA_W-1:0]            data_i,
    input  logic                         eof_i,
    output logic [NUM_TAPS*DATA_W-1:0]   taps_o,
    output logic                         valid_o,
    output logic [clog2(IMG_W)-1:0]      col_o,
    output logic [15:0]                  row_o,
    output logic                         done_o
);

    localparam int          COL_W       = clog2(IMG_W);
    localparam int          FLUSH_BEATS = FLUSH_ROWS * IMG_W;
    localparam int          FC_W        = clog2(FLUSH_BEATS + 1);
    localparam logic [15:0] FULL_ROW    = 16'(NUM_TAPS - 1);

    lba_state_t        state, state_nxt;
    lba_state_t        end_state;
    logic              accept, flush_beat, beat;
    logic              eof_accept, last_col, last_flush, frame_end;
    logic [COL_W-1:0]  col_cnt;
    logic [15:0]       row_cnt;
    logic [FC_W-1:0]   flush_cnt;
    logic [DATA_W-1:0] line [NUM_TAPS];

    // A beat is either an accepted pixel or a self-timed pad; clear_i suppresses both.
    assign ready_o    = !rst && !clear_i && (state != ST_FLUSH);
    assign accept     = valid_i && ready_o;
    assign flush_beat = (state == ST_FLUSH) && !clear_i;
    assign beat       = accept || flush_beat;
    assign eof_accept = accept && eof_i;
    assign last_col   = (col_cnt == COL_W'(IMG_W - 1));
    assign last_flush = flush_beat && (flush_cnt == '0);
    assign frame_end  = (eof_accept && (FLUSH_ROWS == 0)) || last_flush;
    assign end_state  = (FLUSH_ROWS > 0) ? ST_FLUSH : ST_IDLE;
    assign line[0]    = accept ? data_i : PAD_VALUE;

    genvar k;
    generate
        for (k = 0; k < NUM_TAPS - 1; k++) begin : g_rows
            row_delay #(
                .DATA_W (DATA_W),
                .DEPTH  (IMG_W)
            ) u_row_delay (
                .clk  (clk),
                .rst  (rst),
                .en   (beat),
                .din  (line[k]),
                .dout (line[k+1])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (eof_accept)  state_nxt = end_state;
                else if (accept) state_nxt = ST_FILL;
            end
            ST_FILL: begin
                if (eof_accept) state_nxt = end_state;
                else if (accept && last_col && (row_cnt == FULL_ROW - 16'd1))
                    state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (eof_accept) state_nxt = end_state;
            end
            ST_FLUSH: begin
                if (last_flush) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (clear_i) state_nxt = ST_IDLE;
    end

    // Position of the pixel being shifted in; restarts at 0,0 for every frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt   <= '0;
            row_cnt   <= '0;
            flush_cnt <= '0;
        end else if (clear_i) begin
            col_cnt   <= '0;
            row_cnt   <= '0;
            flush_cnt <= '0;
        end else if (beat) begin
            if (frame_end) begin
                col_cnt <= '0;
                row_cnt <= '0;
            end else begin
                col_cnt <= last_col ? '0 : col_cnt + 1'b1;
                if (last_col && (row_cnt != 16'hFFFF)) row_cnt <= row_cnt + 16'd1;
            end
            if (eof_accept)      flush_cnt <= FC_W'((FLUSH_BEATS > 0) ? FLUSH_BEATS - 1 : 0);
            else if (flush_beat) flush_cnt <= flush_cnt - 1'b1;
        end
    end

    // valid_o strobes once per new column, so stalled cycles are never re-consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taps_o  <= '0;
            valid_o <= 1'b0;
            done_o  <= 1'b0;
            col_o   <= '0;
            row_o   <= '0;
        end else if (clear_i) begin
            taps_o  <= '0;
            valid_o <= 1'b0;
            done_o  <= 1'b0;
            col_o   <= '0;
            row_o   <= '0;
        end else begin
            valid_o <= beat && (row_cnt >= FULL_ROW);
            done_o  <= frame_end;
            if (beat) begin
                for (int t = 0; t < NUM_TAPS; t++)
                    taps_o[tap_lsb(t, DATA_W) +: DATA_W] <= line[t];
                col_o <= col_cnt;
                row_o <= row_cnt;
            end
        end
    end

endmodule
